// File: rtl/ambtc_compress.sv
// AMBTC compressor: rewrites a 64x64 grayscale image in place, one 4x4 block at a time.
// Define AMBTC_ROUND_EN to round the block mean half up instead of truncating it.
module ambtc_compress #(
    parameter int IMG_LOG2 = 6,
    parameter int BLK_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [23:0]         in_pix,
    output logic [IMG_LOG2-1:0] row,
    output logic [IMG_LOG2-1:0] col,
    output logic                out_we,
    output logic [23:0]         out_pix,
    output logic                compress_done
);
    localparam int NB_LOG2 = IMG_LOG2 - BLK_LOG2;
    localparam int BI_W    = 2 * NB_LOG2;
    localparam int PI_W    = 2 * BLK_LOG2;
    localparam int CNT_W   = PI_W + 1;
    localparam int SUM_W   = 8 + PI_W;
    localparam int NPIX    = 1 << PI_W;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] CNT_WLAST = CNT_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUM   = 3'd1,
        S_DEV   = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BI_W-1:0]     blk_q, blk_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [SUM_W-1:0]    sum_abs_q, sum_abs_d;
    logic [7:0]          avg_q, avg_d;
    logic [CNT_W-1:0]    beta_q, beta_d;
    logic [NPIX-1:0]     bitmap_q, bitmap_d;
    logic [7:0]          hm_q, hm_d;
    logic [7:0]          lm_q, lm_d;
    logic [IMG_LOG2-1:0] row_q, row_d;
    logic [IMG_LOG2-1:0] col_q, col_d;
    logic                we_q, we_d;
    logic [23:0]         pix_q, pix_d;
    logic                done_q, done_d;

    logic [7:0]          g_s;
    logic                ge_s;
    logic [SUM_W-1:0]    sum_acc_s;
    logic [SUM_W-1:0]    abs_acc_s;
    logic [SUM_W:0]      avg_wide_s;
    logic [PI_W-1:0]     next_idx_s;
    logic [PI_W-1:0]     dev_idx_s;
    logic [PI_W+1:0]     den_hi_s;
    logic [PI_W+1:0]     den_lo_s;
    logic [SUM_W-1:0]    q_hi_s;
    logic [SUM_W-1:0]    q_lo_s;
    logic [SUM_W:0]      hm_sum_s;
    logic [7:0]          hm_calc_s;
    logic [7:0]          lm_calc_s;
    logic                unused_bits_s;

    // Image (row, col) of pixel pix inside block blk, both in row-major order.
    function automatic logic [2*IMG_LOG2-1:0] blk_addr(input logic [BI_W-1:0] blk,
                                                       input logic [PI_W-1:0] pix);
        return {blk[BI_W-1:NB_LOG2], pix[PI_W-1:BLK_LOG2],
                blk[NB_LOG2-1:0],    pix[BLK_LOG2-1:0]};
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign unused_bits_s = ^{in_pix[23:16], in_pix[7:0], avg_wide_s[SUM_W], avg_wide_s[PI_W-1:0]};

    // Block reconstruction levels; a zero-sized side keeps the mean.
    always_comb begin
        den_hi_s = {beta_q, 1'b0};
        den_lo_s = {CNT_LAST - beta_q, 1'b0};
        if (beta_q != '0) begin
            q_hi_s = sum_abs_q / SUM_W'(den_hi_s);
        end else begin
            q_hi_s = '0;
        end
        if (beta_q != CNT_LAST) begin
            q_lo_s = sum_abs_q / SUM_W'(den_lo_s);
        end else begin
            q_lo_s = '0;
        end
        hm_sum_s = (SUM_W+1)'(avg_q) + {1'b0, q_hi_s};
        if (hm_sum_s > (SUM_W+1)'(255)) begin
            hm_calc_s = 8'hFF;
        end else begin
            hm_calc_s = hm_sum_s[7:0];
        end
        if (q_lo_s > SUM_W'(avg_q)) begin
            lm_calc_s = 8'h00;
        end else begin
            lm_calc_s = avg_q - q_lo_s[7:0];
        end
    end

    // Pixel datapath: running sums, mean and per-pixel high/low decision.
    always_comb begin
        g_s        = in_pix[15:8];
        ge_s       = (g_s >= avg_q);
        sum_acc_s  = sum_q + SUM_W'(g_s);
`ifdef AMBTC_ROUND_EN
        avg_wide_s = {1'b0, sum_acc_s} + (SUM_W+1)'(8);
`else
        avg_wide_s = {1'b0, sum_acc_s};
`endif
        abs_acc_s  = sum_abs_q + SUM_W'(abs_diff(g_s, avg_q));
        // After the drain cycle the next read must be pixel 0 again.
        if (cnt_q == CNT_LAST) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = cnt_q[PI_W-1:0] + PI_W'(1);
        end
        dev_idx_s  = cnt_q[PI_W-1:0] - PI_W'(1);
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        sum_d     = sum_q;
        sum_abs_d = sum_abs_q;
        avg_d     = avg_q;
        beta_d    = beta_q;
        bitmap_d  = bitmap_q;
        hm_d      = hm_q;
        lm_d      = lm_q;
        row_d     = row_q;
        col_d     = col_q;
        we_d      = 1'b0;
        pix_d     = 24'h000000;
        done_d    = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_SUM;
                    cnt_d          = '0;
                    blk_d          = '0;
                    sum_d          = '0;
                    {row_d, col_d} = blk_addr('0, '0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUM: begin
                {row_d, col_d} = blk_addr(blk_q, next_idx_s);
                if (cnt_q != '0) begin
                    sum_d = sum_acc_s;
                end else begin
                    sum_d = sum_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DEV;
                    cnt_d     = '0;
                    avg_d     = avg_wide_s[PI_W+7:PI_W];
                    sum_abs_d = '0;
                    beta_d    = '0;
                    bitmap_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DEV: begin
                {row_d, col_d} = blk_addr(blk_q, next_idx_s);
                if (cnt_q != '0) begin
                    sum_abs_d           = abs_acc_s;
                    beta_d              = beta_q + CNT_W'(ge_s);
                    bitmap_d[dev_idx_s] = ge_s;
                end else begin
                    sum_abs_d = sum_abs_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CALC: begin
                hm_d    = hm_calc_s;
                lm_d    = lm_calc_s;
                we_d    = 1'b1;
                pix_d   = {8'h00, (bitmap_q[0] ? hm_calc_s : lm_calc_s), 8'h00};
                state_d = S_WRITE;
                cnt_d   = '0;
            end
            S_WRITE: begin
                if (cnt_q == CNT_WLAST) begin
                    cnt_d = '0;
                    sum_d = '0;
                    if (blk_q == {BI_W{1'b1}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = S_SUM;
                        blk_d          = blk_q + BI_W'(1);
                        {row_d, col_d} = blk_addr(blk_q + BI_W'(1), '0);
                    end
                end else begin
                    we_d           = 1'b1;
                    {row_d, col_d} = blk_addr(blk_q, next_idx_s);
                    pix_d          = {8'h00, (bitmap_q[next_idx_s] ? hm_q : lm_q), 8'h00};
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            blk_q     <= '0;
            sum_q     <= '0;
            sum_abs_q <= '0;
            avg_q     <= 8'h00;
            beta_q    <= '0;
            bitmap_q  <= '0;
            hm_q      <= 8'h00;
            lm_q      <= 8'h00;
            row_q     <= '0;
            col_q     <= '0;
            we_q      <= 1'b0;
            pix_q     <= 24'h000000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_q     <= blk_d;
            sum_q     <= sum_d;
            sum_abs_q <= sum_abs_d;
            avg_q     <= avg_d;
            beta_q    <= beta_d;
            bitmap_q  <= bitmap_d;
            hm_q      <= hm_d;
            lm_q      <= lm_d;
            row_q     <= row_d;
            col_q     <= col_d;
            we_q      <= we_d;
            pix_q     <= pix_d;
            done_q    <= done_d;
        end
    end

    assign row           = row_q;
    assign col           = col_q;
    assign out_we        = we_q;
    assign out_pix       = pix_q;
    assign compress_done = done_q;

endmodule

// File: tb/tb_ambtc_compress.sv
// Bench for ambtc_compress: behavioural image memory, write scoreboard and directed steps.
module tb_ambtc_compress;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] in_pix = 24'd0;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        out_we;
    logic [23:0] out_pix;
    logic        compress_done;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    logic [7:0]  mem [64][64];
    logic [35:0] exp_q [$];
    logic [35:0] mon_e;
    logic [5:0]  prev_row = 6'd0;
    logic [5:0]  prev_col = 6'd0;

    always #5 clk = ~clk;

    ambtc_compress dut (
        .clk(clk), .rst(rst), .start(start), .in_pix(in_pix),
        .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
        .compress_done(compress_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: 1-cycle read latency, writes commit at the edge ending the write cycle.
    always @(negedge clk) begin
        in_pix   = {8'hA5, mem[prev_row][prev_col], 8'h3C};
        prev_row = row;
        prev_col = col;
        if (out_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {40'd0, row, col, out_pix}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {52'd0, row, col}, {52'd0, mon_e[35:24]});
                check("wr_data", {40'd0, out_pix}, {40'd0, mon_e[23:0]});
            end
            mem[row][col] = out_pix[15:8];
        end
    end

    task automatic push_const(input int p, input logic [7:0] v);
        logic [5:0] r, c;
        r = 6'(p / 4);
        c = 6'(p % 4);
        exp_q.push_back({r, c, 8'h00, v, 8'h00});
    endtask

    task automatic set_b0(input int p, input logic [7:0] v);
        mem[p / 4][p % 4] = v;
    endtask

    // Software AMBTC of block k from the current memory contents.
    task automatic push_block_model(input int k);
        int br, bc, sum, avg, beta, sabs, hm, lm, g;
        logic [5:0] r, c;
        logic [7:0] v;
        br = (k / 16) * 4;
        bc = (k % 16) * 4;
        sum = 0;
        for (int p = 0; p < 16; p++) sum += int'(mem[br + p / 4][bc + p % 4]);
`ifdef AMBTC_ROUND_EN
        avg = (sum + 8) / 16;
`else
        avg = sum / 16;
`endif
        beta = 0;
        sabs = 0;
        for (int p = 0; p < 16; p++) begin
            g = int'(mem[br + p / 4][bc + p % 4]);
            if (g >= avg) begin
                beta++;
                sabs += g - avg;
            end else begin
                sabs += avg - g;
            end
        end
        hm = (beta == 0) ? avg : avg + sabs / (2 * beta);
        if (hm > 255) hm = 255;
        lm = (beta == 16) ? avg : avg - sabs / (2 * (16 - beta));
        if (lm < 0) lm = 0;
        for (int p = 0; p < 16; p++) begin
            g = int'(mem[br + p / 4][bc + p % 4]);
            r = 6'(br + p / 4);
            c = 6'(bc + p % 4);
            v = 8'((g >= avg) ? hm : lm);
            exp_q.push_back({r, c, 8'h00, v, 8'h00});
        end
    endtask

    task automatic pulse_reset();
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_block0(input string tag);
        int base, first_w;
        base    = wr_cnt;
        first_w = 0;
        start   = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            if (out_we === 1'b1 && first_w == 0) first_w = c;
        end
        #1;
        check({tag, "_first_write_cycle"}, 64'(first_w), 64'd36);
        check({tag, "_write_count"}, 64'(wr_cnt - base), 64'd16);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        pulse_reset();
    endtask

    task automatic run_full(input string tag);
        int base, done_c;
        exp_q.delete();
        for (int k = 0; k < 256; k++) push_block_model(k);
        base   = wr_cnt;
        done_c = 0;
        start  = 1'b1;
        for (int c = 1; c <= 13200 && done_c == 0; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
            if (compress_done === 1'b1) done_c = c;
        end
        #1;
        check({tag, "_done_cycle"}, 64'(done_c), 64'd13057);
        check({tag, "_write_count"}, 64'(wr_cnt - base), 64'd4096);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        start = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_done_hold"}, 64'(compress_done), 64'd1);
        check({tag, "_done_we"}, 64'(out_we), 64'd0);
        check({tag, "_done_pix"}, 64'(out_pix), 64'd0);
        start = 1'b0;
    endtask

    initial begin
        int base;
        rst   = 1'b1;
        start = 1'b0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_row", 64'(row), 64'd0);
        check("rst_col", 64'(col), 64'd0);
        check("rst_we", 64'(out_we), 64'd0);
        check("rst_pix", 64'(out_pix), 64'd0);
        check("rst_done", 64'(compress_done), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_we", 64'(out_we), 64'd0);
        check("idle_done", 64'(compress_done), 64'd0);

        for (int p = 0; p < 16; p++) begin
            set_b0(p, 8'd100);
            push_const(p, 8'd100);
        end
        run_block0("uniform");

        for (int p = 0; p < 16; p++) begin
            set_b0(p, (p % 2 == 0) ? 8'd200 : 8'd0);
            push_const(p, (p % 2 == 0) ? 8'd200 : 8'd0);
        end
        run_block0("half_split");

        for (int p = 0; p < 16; p++) begin
            set_b0(p, (p == 5) ? 8'd250 : 8'd10);
            push_const(p, (p == 5) ? 8'd250 : 8'd10);
        end
        run_block0("outlier");

        for (int p = 0; p < 16; p++) begin
            set_b0(p, (p < 8) ? 8'd0 : 8'd201);
`ifdef AMBTC_ROUND_EN
            push_const(p, (p < 8) ? 8'd1 : 8'd201);
`else
            push_const(p, (p < 8) ? 8'd0 : 8'd200);
`endif
        end
        run_block0("rounding");

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 8'($urandom_range(0, 255));
        run_full("full");

        pulse_reset();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) mem[r][c] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) push_block_model(k);
        base  = wr_cnt;
        start = 1'b1;
        for (int c = 1; c <= 1927; c++) begin
            @(negedge clk);
            if (c == 3) start = 1'b0;
        end
        check("mid_we_before", 64'(out_we), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(out_we), 64'd0);
        check("mid_rst_pix", 64'(out_pix), 64'd0);
        check("mid_rst_row", 64'(row), 64'd0);
        check("mid_rst_col", 64'(col), 64'd0);
        check("mid_rst_done", 64'(compress_done), 64'd0);
        check("mid_write_count", 64'(wr_cnt - base), 64'd597);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        run_full("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ambtc_compress.md
Name: ambtc_compress

Overview:
- Second stage of the image pipeline, directly downstream of the grayscale stage.
- Starts when grayscale completes, using the grayscale `gray_done` output as `start`.
- Compresses the 64x64 grayscale image (value in G channel) in place using AMBTC (Absolute Moment Block Truncation Coding) on 4x4 blocks.
- Drives the shared image row/col bus and write port, then raises `compress_done` for the downstream encode stage.

Parameters:
- IMG_LOG2, 6, log2 of image side; the image is 64x64, which fixes the row/col width.
- BLK_LOG2, 2, log2 of block side; the block is 4x4 (16 pixels). Only the default is required to work.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level; wired to the grayscale `gray_done`; sampled only in IDLE.
- in_pix  in  24  pixel at the previously presented (row, col); R 23:16, G 15:8, B 7:0. Only G is used.
- row  out  6  image row select, registered.
- col  out  6  image column select, registered.
- out_we  out  1  write enable for (row, col) in the same cycle, registered.
- out_pix  out  24  write data, registered; always {8'h00, value, 8'h00}.
- compress_done  out  1  high once the whole image is written, registered.

Behaviour:
- **Reset:** rst=1 asynchronously clears row, col, out_we, out_pix, compress_done, all accumulators and the block counters, and forces IDLE. Reset mid-operation abandons the current block; pixels already written stay written. After release, the block waits in IDLE for start.
- **Memory timing:** read latency is 1 cycle; in_pix for the address presented in cycle n is sampled at the end of cycle n+1. A write commits at the rising edge closing the cycle in which out_we=1.
- **Scan order:** blocks row-major (block k, k=0..255, has top-left corner (4*(k/16), 4*(k%16))). Pixels within a block are row-major.
- **FSM states and transitions:**
  - IDLE: start=1 moves to SUM; otherwise stays.
  - SUM: present the 16 addresses in 16 cycles, plus 1 drain cycle, for 17 cycles. Accumulate sum (12 bits, max 4080). On exit, avg = sum>>4 (8 bits).
  - DEV: re-read the same 16 pixels, 17 cycles. Accumulate sum_abs += |x-avg| (12 bits). Count beta = number of pixels with x >= avg (5 bits, 0..16).
  - CALC: 1 cycle.
    - Hm = avg + floor(sum_abs / (2*beta)).
    - Lm = avg - floor(sum_abs / (2*(16-beta))).
    - beta==16: Lm = avg (no division by zero).
    - beta==0: Hm = avg (defensive; unreachable with floor avg).
    - Both results saturate to 0..255.
    - The divider may be combinational; the 1-cycle budget is fixed.
  - WRITE: 16 cycles, out_we=1 each cycle. out_pix G = Hm if the pixel's value from DEV was >= avg, else Lm. A 16-bit bitmap captured in DEV holds these decisions; pixels are not re-read.
  - Block advance: after WRITE, if k<255 then k++ and go to SUM; otherwise go to DONE.
  - DONE: compress_done=1, out_we=0. Stays in DONE until reset, regardless of start.
- **Latency:** exactly 51 cycles per block.
  - Cycle 0 is the cycle whose rising edge samples start=1 in IDLE.
  - Block k occupies cycles 51k+1 .. 51k+51.
  - compress_done is first high in cycle 13057.
- **Outside WRITE:** out_we=0 and out_pix holds 0.
- **Start deassertion:** start deasserting after leaving IDLE has no effect.

Optional Feature:
- Macro: AMBTC_ROUND_EN.
- Defined: avg = (sum+8)>>4, i.e. round half up. beta, sum_abs, Hm and Lm all use this rounded avg. The sum_abs accumulator stays 12 bits.
- Undefined: avg = sum>>4 (floor).
- Timing is identical either way.

Test Plan:
- **Uniform block:** all 16 pixels of block 0 G=100 -> beta=16, Hm=Lm=100. All 16 writes carry out_pix=24'h006400.
- **Half split:** 8 pixels G=0 and 8 pixels G=200 -> avg=100, sum_abs=1600, beta=8. Written values are exactly 200 (high) and 0 (low).
- **Outlier:** 15 pixels G=10, one G=250 -> sum=400, avg=25, beta=1, sum_abs=450. Hm=250 and Lm=25-15=10; one write of 250, fifteen writes of 10.
- **Full image timing:** random image, start rises at cycle 0.
  - Exactly 4096 writes occur, each address exactly once, in the scan order above.
  - compress_done is first high in cycle 13057 and stays high.
  - Results match a software AMBTC model.
- **Reset mid-operation:** assert rst during block 37 WRITE -> outputs clear immediately (asynchronous). After release with start=1, a full rerun completes with correct image and timing.
- **AMBTC_ROUND_EN:** 8 pixels G=0 and 8 pixels G=201.
  - Without the macro: written values 200/0.
  - With the macro: avg=101, written values 201/1.
